idct8_core: RTL and testbench

Streaming 8-point inverse DCT. It accepts coefficient blocks X(0..7) in natural order, one sample per cycle, on the same valid-qualified serial interface that dct8_core drives, and emits reconstructed samples x(0..7) in order. It uses direct matrix evaluation: a ping-pong coefficient buffer, 8 constant multipliers, and a 3-stage pipelined adder tree. It sits on the decode or verification side of the DCT datapath, downstream of dct8_core or any quantiser/dequantiser.

---
 rtl/idct8_core.sv | 213 +++++++++++++++++++++
 tb/tb_idct8_core.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/idct8_core.sv
// Streaming 8-point inverse DCT by direct matrix evaluation: ping-pong coefficient
// banks, eight constant multipliers and a registered adder tree with round/saturate.
module idct8_core #(
  parameter int DATA_WIDTH = 12,
  parameter int COEF_WIDTH = 12,
  parameter int COEF_FRAC  = 11
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] in_sample,
  input  logic                         in_valid,
  output logic signed [DATA_WIDTH-1:0] out_sample,
  output logic                         out_valid,
  output logic [2:0]                   out_index,
  output logic                         out_last
);

  localparam int PW  = DATA_WIDTH + COEF_WIDTH;
  localparam int S2W = PW + 2;
  localparam int S3W = PW + 3;
  localparam int RW  = S3W + 1;

  localparam logic signed [RW-1:0] RND     = RW'(2'sd1) <<< (COEF_FRAC - 1);
  localparam logic signed [RW-1:0] SAT_MAX = RW'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] SAT_MIN = RW'(-(64'sd1 <<< (DATA_WIDTH - 1)));

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Orthonormal IDCT constant for output n, coefficient k, scaled by 2^11.
  // The angle (2n+1)k*pi/16 is folded into the first quadrant by its index mod 32.
  function automatic logic signed [COEF_WIDTH-1:0] rom_coef(input logic [2:0] n, input logic [2:0] k);
    logic [4:0] m;
    logic [3:0] r;
    logic       neg;
    logic signed [COEF_WIDTH-1:0] mag;
    m = 5'(({2'b00, n, 1'b1}) * {3'b000, k});
    if (m <= 5'd8) begin
      r = m[3:0];
      neg = 1'b0;
    end else if (m <= 5'd16) begin
      r = 4'(5'd16 - m);
      neg = 1'b1;
    end else if (m <= 5'd24) begin
      r = 4'(m - 5'd16);
      neg = 1'b1;
    end else begin
      r = 4'(6'd32 - {1'b0, m});
      neg = 1'b0;
    end
    case (r)
      4'd0:    mag = COEF_WIDTH'(12'sd1024);
      4'd1:    mag = COEF_WIDTH'(12'sd1004);
      4'd2:    mag = COEF_WIDTH'(12'sd946);
      4'd3:    mag = COEF_WIDTH'(12'sd851);
      4'd4:    mag = COEF_WIDTH'(12'sd724);
      4'd5:    mag = COEF_WIDTH'(12'sd569);
      4'd6:    mag = COEF_WIDTH'(12'sd392);
      4'd7:    mag = COEF_WIDTH'(12'sd200);
      default: mag = COEF_WIDTH'(12'sd0);
    endcase
    if (k == 3'd0) begin
      mag = COEF_WIDTH'(12'sd724);
      neg = 1'b0;
    end
    return neg ? -mag : mag;
  endfunction

  logic [2:0]                   wr_idx_q;
  logic                         wr_bank_q;
  logic                         start_s;
  logic signed [DATA_WIDTH-1:0] bank_q [2][8];

  state_t     state_q;
  logic [2:0] rd_idx_q;
  logic       rd_bank_q;

  logic signed [COEF_WIDTH-1:0] coef_s [8];
  logic signed [PW-1:0]         prod_d [8];
  logic signed [PW-1:0]         prod_q [8];
  logic signed [S2W-1:0]        psum_q [2];
  logic                         v1_q, v2_q, last1_q, last2_q;
  logic [2:0]                   idx1_q, idx2_q;

  logic signed [S3W-1:0]        sum_full_s;
  logic signed [RW-1:0]         rnd_s;
  logic signed [RW-1:0]         shr_s;
  logic signed [DATA_WIDTH-1:0] sat_s;

  logic signed [DATA_WIDTH-1:0] out_sample_q;
  logic                         out_valid_q, out_last_q;
  logic [2:0]                   out_index_q;

  assign start_s = in_valid && (wr_idx_q == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q  <= 3'd0;
      wr_bank_q <= 1'b0;
    end else if (in_valid) begin
      wr_idx_q <= wr_idx_q + 3'd1;
      if (wr_idx_q == 3'd7) begin
        wr_bank_q <= ~wr_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      bank_q[wr_bank_q][wr_idx_q] <= in_sample;
    end
  end

  // A start arriving with rd_idx = 7 chains straight into the next block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_idx_q  <= 3'd0;
      rd_bank_q <= 1'b0;
      v1_q      <= 1'b0;
      idx1_q    <= 3'd0;
      last1_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_s) begin
            state_q   <= RUN;
            rd_idx_q  <= 3'd0;
            rd_bank_q <= wr_bank_q;
          end
        end
        RUN: begin
          if (start_s) begin
            rd_idx_q  <= 3'd0;
            rd_bank_q <= wr_bank_q;
          end else if (rd_idx_q == 3'd7) begin
            state_q  <= IDLE;
            rd_idx_q <= 3'd0;
          end else begin
            rd_idx_q <= rd_idx_q + 3'd1;
          end
        end
        default: begin
          state_q  <= IDLE;
          rd_idx_q <= 3'd0;
        end
      endcase
      v1_q    <= (state_q == RUN);
      idx1_q  <= rd_idx_q;
      last1_q <= (state_q == RUN) && (rd_idx_q == 3'd7);
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      coef_s[k] = rom_coef(rd_idx_q, 3'(k));
      prod_d[k] = PW'(bank_q[rd_bank_q][k]) * PW'(coef_s[k]);
    end
  end

  always_ff @(posedge clk) begin
    prod_q    <= prod_d;
    psum_q[0] <= S2W'(prod_q[0]) + S2W'(prod_q[1]) + S2W'(prod_q[2]) + S2W'(prod_q[3]);
    psum_q[1] <= S2W'(prod_q[4]) + S2W'(prod_q[5]) + S2W'(prod_q[6]) + S2W'(prod_q[7]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      idx2_q  <= 3'd0;
      last2_q <= 1'b0;
    end else begin
      v2_q    <= v1_q;
      idx2_q  <= idx1_q;
      last2_q <= last1_q;
    end
  end

  always_comb begin
    sum_full_s = S3W'(psum_q[0]) + S3W'(psum_q[1]);
    rnd_s      = RW'(sum_full_s) + RND;
    shr_s      = rnd_s >>> COEF_FRAC;
    if (shr_s > SAT_MAX) begin
      sat_s = DATA_WIDTH'(SAT_MAX);
    end else if (shr_s < SAT_MIN) begin
      sat_s = DATA_WIDTH'(SAT_MIN);
    end else begin
      sat_s = DATA_WIDTH'(shr_s);
    end
  end

  // Sample and index hold their last value between bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      out_index_q  <= 3'd0;
      out_last_q   <= 1'b0;
    end else begin
      out_valid_q <= v2_q;
      out_last_q  <= v2_q && last2_q;
      if (v2_q) begin
        out_sample_q <= sat_s;
        out_index_q  <= idx2_q;
      end
    end
  end

  assign out_sample = out_sample_q;
  assign out_valid  = out_valid_q;
  assign out_index  = out_index_q;
  assign out_last   = out_last_q;

endmodule

// File: tb/tb_idct8_core.sv
// Scoreboard bench for idct8_core: a real-valued reference model predicts each sample
// and the cycle it must appear; a monitor pops and compares whatever the DUT emits.
module tb_idct8_core;

  logic               clk;
  logic               rst_n;
  logic signed [11:0] in_sample;
  logic               in_valid;
  logic signed [11:0] out_sample;
  logic               out_valid;
  logic [2:0]         out_index;
  logic               out_last;

  typedef struct {
    int val;
    int idx;
    int due;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   blk[4][8];
  int   xs[8];
  int   t_edge;

  idct8_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_sample  (in_sample),
    .in_valid   (in_valid),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .out_index  (out_index),
    .out_last   (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    else passes++;
  endtask

  // x(n) = sum c(k) X(k) cos((2n+1)k pi/16) with constants rounded to 2^-11, then round/shift/clamp.
  function automatic int ref_x(input int xv[8], input int n);
    real    c;
    longint acc;
    longint r;
    int     ci;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      c = ((k == 0) ? 1.0 / $sqrt(8.0) : 0.5) * $cos((2.0 * n + 1.0) * k * 3.14159265358979 / 16.0) * 2048.0;
      ci = $rtoi((c >= 0.0) ? c + 0.5 : c - 0.5);
      acc += longint'(xv[k]) * longint'(ci);
    end
    r = (acc + 64'sd1024) >>> 11;
    if (r > 2047) r = 2047;
    if (r < -2048) r = -2048;
    return int'(r);
  endfunction

  // gap_mode: 0 contiguous, 1 idle cycle between samples, 2 random idle gaps.
  task automatic send_block(input int xv[8], input int gap_mode, output int t);
    int g;
    t = 0;
    for (int k = 0; k < 8; k++) begin
      g = (gap_mode == 1 && k > 0) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      repeat (g) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid  = 1'b1;
      in_sample = 12'(xv[k]);
      if (k == 7) begin
        t = cyc + 1;
        for (int n = 0; n < 8; n++) q.push_back('{ref_x(xv, n), n, t + 3 + n});
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"},  int'(out_valid),  0);
    chk({tag, "_out_sample"}, int'(out_sample), 0);
    chk({tag, "_out_index"},  int'(out_index),  0);
    chk({tag, "_out_last"},   int'(out_last),   0);
  endtask

  task automatic pulse_reset(input string tag, input int ncyc);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    #1;
    check_reset_outputs(tag);
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid", int'(out_valid), 0);
      end else begin
        e = q.pop_front();
        chk("sample", int'(out_sample), e.val);
        chk("index",  int'(out_index),  e.idx);
        chk("last",   int'(out_last),   (e.idx == 7) ? 1 : 0);
        chk("cycle",  cyc,              e.due);
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("missing_out", int'(out_valid), 1);
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sample = 12'sd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    xs = '{1024, 0, 0, 0, 0, 0, 0, 0};
    send_block(xs, 0, t_edge);
    idle(12);

    xs = '{0, 0, 0, 0, 512, 0, 0, 0};
    send_block(xs, 0, t_edge);
    idle(12);

    xs = '{2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047};
    send_block(xs, 0, t_edge);
    xs = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048};
    send_block(xs, 0, t_edge);
    idle(12);

    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 8; k++) blk[b][k] = int'($urandom_range(0, 4095)) - 2048;
    for (int b = 0; b < 4; b++) send_block(blk[b], 0, t_edge);
    idle(12);
    for (int b = 0; b < 4; b++) send_block(blk[b], 1, t_edge);
    idle(12);
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) xs[k] = int'($urandom_range(0, 4095)) - 2048;
      send_block(xs, 2, t_edge);
    end
    idle(12);

    // Partial block followed by reset must leave no trace.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_sample = 12'sd300;
    end
    @(posedge clk);
    #3;
    pulse_reset("midblock", 2);
    xs = '{1024, 0, 0, 0, 0, 0, 0, 0};
    send_block(xs, 0, t_edge);
    idle(12);

    // Reset while x(3) is on the output.
    xs = '{700, -300, 250, 0, -512, 90, 33, -1000};
    send_block(xs, 0, t_edge);
    idle(1);
    while (cyc < t_edge + 6) @(posedge clk);
    #2;
    pulse_reset("midburst", 2);
    idle(20);
    xs = '{1024, 0, 0, 0, 0, 0, 0, 0};
    send_block(xs, 0, t_edge);
    idle(20);

    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
